// File: rtl/capture_ram_ring.sv
// Circular trace-capture RAM with arm/trigger/post-trigger control and linearised readback.
// Optional per-sample cycle timestamps are built when CAPTURE_TIMESTAMP_EN is defined.
module capture_ram_ring #(
    parameter int DATA_WIDTH = 1260,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  cap_valid,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [1:0]            state,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic [31:0]           rd_ts
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                st_q, st_n;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_n;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_n;
    logic                  wrapped_q, wrapped_n;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_accept;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    assign wr_ptr_inc   = wr_ptr_q + 1'b1;
    assign state        = st_q;
    assign sample_count = wrapped_q ? (ADDR_WIDTH + 1)'(DEPTH) : {1'b0, wr_ptr_q};
    assign base         = wrapped_q ? wr_ptr_q : '0;

    // A read in the arm cycle is refused so the port never sees a read and a write back to back across modes.
    assign rd_accept = rd_en && !arm && ((st_q == S_IDLE) || (st_q == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= S_IDLE;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            wrapped_q   <= 1'b0;
        end else begin
            st_q        <= st_n;
            wr_ptr_q    <= wr_ptr_n;
            remaining_q <= remaining_n;
            wrapped_q   <= wrapped_n;
        end
    end

    always_comb begin
        st_n        = st_q;
        wr_ptr_n    = wr_ptr_q;
        remaining_n = remaining_q;
        wrapped_n   = wrapped_q;
        wr_en       = 1'b0;
        if (arm) begin
            st_n      = S_PRE;
            wr_ptr_n  = '0;
            wrapped_n = 1'b0;
        end else begin
            case (st_q)
                S_PRE: begin
                    if (cap_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_n = wr_ptr_inc;
                        if (&wr_ptr_q) begin
                            wrapped_n = 1'b1;
                        end
                    end
                    // The sample sharing the trigger cycle is stored but not counted against post_count.
                    if (trig) begin
                        remaining_n = post_count;
                        st_n        = (post_count == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (cap_valid) begin
                        wr_en       = 1'b1;
                        wr_ptr_n    = wr_ptr_inc;
                        remaining_n = remaining_q - 1'b1;
                        if (&wr_ptr_q) begin
                            wrapped_n = 1'b1;
                        end
                        if (remaining_q <= ADDR_WIDTH'(1)) begin
                            st_n = S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= cap_data;
        end
    end

    // Stage p0: logical offset translated to a physical address.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= rd_accept;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_accept) begin
            addr_p0 <= base + rd_addr;
        end
    end

    // Stage p1: registered RAM read, presented directly as the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
        end else if (vld_p0) begin
            data_p1 <= mem[addr_p0];
        end
    end

    assign rd_data  = data_p1;
    assign rd_valid = vld_p1;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];
    logic [31:0] ts_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ts_mem[wr_ptr_q] <= ts_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_p1 <= '0;
        end else if (vld_p0) begin
            ts_p1 <= ts_mem[addr_p0];
        end
    end

    assign rd_ts = ts_p1;
`else
    assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_capture_ram_ring.sv
// Directed self-checking bench for capture_ram_ring (DEPTH=16, DATA_WIDTH=1260).
module tb_capture_ram_ring;

    localparam int DW = 1260;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          trig;
    logic [AW-1:0] post_count;
    logic          cap_valid;
    logic [DW-1:0] cap_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    state;
    logic [AW:0]   sample_count;
    logic [31:0]   rd_ts;

    int total = 0;
    int bad   = 0;

    capture_ram_ring #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .post_count(post_count),
        .cap_valid(cap_valid), .cap_data(cap_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
        .sample_count(sample_count), .rd_ts(rd_ts)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        arm = 0; trig = 0; post_count = '0; cap_valid = 0; cap_data = '0;
        rd_en = 0; rd_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic push(input int v);
        cap_valid = 1; cap_data = DW'(v);
        step();
        cap_valid = 0;
    endtask

    task automatic read_one(input int a, output logic [DW-1:0] d, output logic v, output logic [31:0] ts);
        rd_en = 1; rd_addr = AW'(a);
        step();
        rd_en = 0;
        step();
        d = rd_data; v = rd_valid; ts = rd_ts;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (sample_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", sample_count); end
        total++; if (rd_valid !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL reset_rd got_vld=%0b want=0", rd_valid); end
    endtask

    task automatic test_basic_capture();
        arm = 1; step(); arm = 0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL arm_pre got=%0d want=1", state); end
        for (int k = 1; k <= 5; k++) push(k);
        trig = 1; post_count = 4'd3; cap_valid = 1; cap_data = DW'(6);
        step();
        trig = 0; cap_valid = 0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL trig_post got=%0d want=2", state); end
        push(7);
        push(8);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL post_hold got=%0d want=2", state); end
        push(9);
        total++; if (state !== 2'd3) begin bad++; $display("FAIL post_done got=%0d want=3", state); end
        total++; if (sample_count !== 5'd9) begin bad++; $display("FAIL count9 got=%0d want=9", sample_count); end
        for (int i = 0; i < 10; i++) begin
            rd_en = (i < 9); rd_addr = AW'(i);
            step();
            total++;
            if (i == 0) begin
                if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_latency got_vld=%0b want=0", rd_valid); end
            end else if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
                bad++; $display("FAIL rd_lin%0d got_vld=%0b got=%0h want=%0h", i - 1, rd_valid, rd_data[31:0], i);
            end
        end
        rd_en = 0;
        step();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_end got_vld=%0b want=0", rd_valid); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d; logic v; logic [31:0] ts;
        arm = 1; step(); arm = 0;
        for (int k = 0; k < 20; k++) push(k);
        trig = 1; post_count = 4'd0; step(); trig = 0;
        total++; if (state !== 2'd3) begin bad++; $display("FAIL wrap_done got=%0d want=3", state); end
        total++; if (sample_count !== 5'd16) begin bad++; $display("FAIL wrap_count got=%0d want=16", sample_count); end
        read_one(0, d, v, ts);
        total++; if (v !== 1'b1 || d !== DW'(4)) begin bad++; $display("FAIL wrap_rd0 got=%0h want=4", d[31:0]); end
        read_one(15, d, v, ts);
        total++; if (v !== 1'b1 || d !== DW'(19)) begin bad++; $display("FAIL wrap_rd15 got=%0h want=13", d[31:0]); end
        read_one(7, d, v, ts);
        total++; if (v !== 1'b1 || d !== DW'(11)) begin bad++; $display("FAIL wrap_rd7 got=%0h want=b", d[31:0]); end
    endtask

    task automatic test_arm_trig();
        logic [DW-1:0] d; logic v; logic [31:0] ts;
        arm = 1; trig = 1; post_count = 4'd0;
        step();
        arm = 0; trig = 0;
        total++; if (state !== 2'd1) begin bad++; $display("FAIL armtrig_state got=%0d want=1", state); end
        total++; if (sample_count !== 5'd0) begin bad++; $display("FAIL armtrig_count got=%0d want=0", sample_count); end
        push(32'h31);
        push(32'h32);
        trig = 1; post_count = 4'd1; step(); trig = 0;
        total++; if (state !== 2'd2) begin bad++; $display("FAIL late_trig got=%0d want=2", state); end
        push(32'h33);
        total++; if (state !== 2'd3 || sample_count !== 5'd3) begin bad++; $display("FAIL late_done got=%0d/%0d want=3/3", state, sample_count); end
        read_one(2, d, v, ts);
        total++; if (v !== 1'b1 || d !== DW'(32'h33)) begin bad++; $display("FAIL late_rd2 got=%0h want=33", d[31:0]); end
    endtask

    task automatic test_back_to_back();
        arm = 1; step(); arm = 0;
        push(32'hA0);
        push(32'hA1);
        trig = 1; post_count = 4'd3; rd_en = 1; rd_addr = '0; step(); trig = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_in_post%0d got_vld=%0b want=0", i, rd_valid); end
        end
        rd_en = 0;
        push(32'hA2);
        push(32'hA3);
        push(32'hA4);
        total++; if (state !== 2'd3) begin bad++; $display("FAIL b2b_done got=%0d want=3", state); end
        for (int i = 0; i < 6; i++) begin
            rd_en = (i < 4); rd_addr = AW'(i);
            step();
            total++;
            if (i >= 1 && i <= 4) begin
                if (rd_valid !== 1'b1 || rd_data !== DW'(32'hA0 + i - 1)) begin
                    bad++; $display("FAIL b2b_rd%0d got_vld=%0b got=%0h want=%0h", i - 1, rd_valid, rd_data[31:0], 32'hA0 + i - 1);
                end
            end else if (rd_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_idle%0d got_vld=%0b want=0", i, rd_valid);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_reset_mid();
        arm = 1; step(); arm = 0;
        trig = 1; post_count = 4'd3; step(); trig = 0;
        push(32'h51);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL mid_post got=%0d want=2", state); end
        rst = 1; cap_valid = 1; cap_data = DW'(32'h52);
        step();
        rst = 0;
        total++; if (state !== 2'd0 || sample_count !== 5'd0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL mid_rst got=%0d/%0d/%0b want=0/0/0", state, sample_count, rd_valid);
        end
        step();
        cap_valid = 0;
        total++; if (state !== 2'd0 || sample_count !== 5'd0) begin bad++; $display("FAIL idle_nowrite got=%0d/%0d want=0/0", state, sample_count); end
        rd_en = 1; rd_addr = '0; step(); rd_en = 0;
        rst = 1; step(); rst = 0;
        total++; if (rd_valid !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL rd_flush got_vld=%0b want=0", rd_valid); end
    endtask

    task automatic test_timestamp();
        logic [DW-1:0] d; logic v; logic [31:0] ts;
        do_reset();
        arm = 1; step(); arm = 0;
        for (int c = 1; c < 10; c++) step();
        push(32'h61);
        step();
        step();
        push(32'h62);
        trig = 1; post_count = 4'd0; step(); trig = 0;
        read_one(0, d, v, ts);
        total++; if (v !== 1'b1 || d !== DW'(32'h61)) begin bad++; $display("FAIL ts_data0 got=%0h want=61", d[31:0]); end
`ifdef CAPTURE_TIMESTAMP_EN
        total++; if (ts !== 32'd10) begin bad++; $display("FAIL ts0 got=%0d want=10", ts); end
`else
        total++; if (ts !== 32'd0) begin bad++; $display("FAIL ts0 got=%0d want=0", ts); end
`endif
        read_one(1, d, v, ts);
        total++; if (v !== 1'b1 || d !== DW'(32'h62)) begin bad++; $display("FAIL ts_data1 got=%0h want=62", d[31:0]); end
`ifdef CAPTURE_TIMESTAMP_EN
        total++; if (ts !== 32'd13) begin bad++; $display("FAIL ts1 got=%0d want=13", ts); end
`else
        total++; if (ts !== 32'd0) begin bad++; $display("FAIL ts1 got=%0d want=0", ts); end
`endif
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_basic_capture();
        test_wrap();
        test_arm_trig();
        test_back_to_back();
        test_reset_mid();
        test_timestamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
